hive_reg_bank: RTL

// - Parametrised bank of REG_N rbus registers with a per-register mode, sticky event capture and interrupt aggregation.
// - One rbus slave decode and one registered read mux replace per-register instances OR'd together.
// - Sits between the hive core rbus and peripheral status/control signals.
// - Registers are at BASE..BASE+REG_N-1; IRQ enable is at BASE+REG_N; the lock register is at BASE+REG_N+1.

---
 rtl/hive_reg_pkg.sv | 30 +++
 rtl/hive_reg_slot.sv | 43 ++++
 rtl/in_cond.sv | 28 ++
 rtl/hive_reg_bank.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/hive_reg_pkg.sv
// Shared types and address-offset helpers for the hive register bank.
// Optional feature macro (used by hive_reg_bank): HIVE_REG_BANK_LOCK_EN.
package hive_reg_pkg;

   // Per-register behaviour code, two bits per register in MODE_VEC.
   typedef enum logic [1:0] {
      RW  = 2'd0,
      RO  = 2'd1,
      W1C = 2'd2,
      RC  = 2'd3
   } mode_t;

   // Write-lock state; the encoding is what the lock register reads back.
   typedef enum logic [1:0] {
      LOCKED = 2'd0,
      ARMED  = 2'd1,
      OPEN   = 2'd2
   } lock_st_t;

   // IRQ enable sits just above the data registers.
   function automatic int irq_ofs(input int reg_n);
      return reg_n;
   endfunction

   // Lock register sits just above the IRQ enable.
   function automatic int lock_ofs(input int reg_n);
      return reg_n + 1;
   endfunction

endpackage

// File: rtl/hive_reg_slot.sv
// One register of the hive bank: mode-dependent update, live-bit masking.
module hive_reg_slot
   import hive_reg_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter mode_t             MODE      = RW,
   parameter logic [DATA_W-1:0] LIVE      = '1,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              wr_i,       // accepted write to this register
   input  logic              rd_i,       // read of this register (RC clear)
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [DATA_W-1:0] cond_i,     // conditioned peripheral input
   output logic [DATA_W-1:0] data_o
);

   logic [DATA_W-1:0] data_reg;
   logic [DATA_W-1:0] data_next;

   // Next value per mode; for W1C/RC the input set is OR'd last so it wins.
   always_comb begin
      data_next = data_reg;
      case (MODE)
         RW:      if (wr_i) data_next = wr_data_i;
         RO:      data_next = cond_i;
         W1C:     data_next = (data_reg & ~(wr_i ? wr_data_i : '0)) | cond_i;
         RC:      data_next = (rd_i ? '0 : data_reg) | cond_i;
         default: data_next = data_reg;
      endcase
      data_next = data_next & LIVE;
   end

   // Stored value register.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) data_reg <= RESET_VAL & LIVE;
      else          data_reg <= data_next;
   end

   assign data_o = data_reg;

endmodule

// File: rtl/in_cond.sv
// Input conditioning: bits selected by SYNC_MASK pass through a SYNC_W-deep
// resync chain, all other bits pass straight through.
module in_cond #(
   parameter int              W         = 1,
   parameter int              SYNC_W    = 2,
   parameter logic [W-1:0]    SYNC_MASK = '0
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o
);

   logic [W-1:0] sync_reg [SYNC_W];

   // Resync shift chain, cleared by reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < SYNC_W; i++) sync_reg[i] <= '0;
      end else begin
         sync_reg[0] <= data_i;
         for (int i = 1; i < SYNC_W; i++) sync_reg[i] <= sync_reg[i-1];
      end
   end

   assign data_o = (sync_reg[SYNC_W-1] & SYNC_MASK) | (data_i & ~SYNC_MASK);

endmodule

// File: rtl/hive_reg_bank.sv
// Bank of REG_N rbus registers with per-register mode, sticky event capture
// and interrupt aggregation. Optional write lock: HIVE_REG_BANK_LOCK_EN.
module hive_reg_bank
   import hive_reg_pkg::*;
#(
   parameter int                       DATA_W    = 32,
   parameter int                       ADDR_W    = 4,
   parameter int                       REG_N     = 8,
   parameter int                       BASE      = 0,
   parameter int                       SYNC_W    = 2,
   parameter logic [2*REG_N-1:0]       MODE_VEC  = '0,
   parameter logic [REG_N*DATA_W-1:0]  LIVE_VEC  = '1,
   parameter logic [REG_N*DATA_W-1:0]  SYNC_VEC  = '0,
   parameter logic [REG_N*DATA_W-1:0]  RESET_VEC = '0,
   parameter logic [15:0]              LOCK_KEY  = 16'hA5C3
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic [ADDR_W-1:0]         rbus_addr_i,
   input  logic                      rbus_wr_i,
   input  logic                      rbus_rd_i,
   input  logic [DATA_W-1:0]         rbus_wr_data_i,
   output logic [DATA_W-1:0]         rbus_rd_data_o,
   output logic [REG_N-1:0]          reg_wr_o,
   output logic [REG_N-1:0]          reg_rd_o,
   output logic [REG_N*DATA_W-1:0]   reg_data_o,
   input  logic [REG_N*DATA_W-1:0]   reg_data_i,
   output logic                      irq_o,
   output logic                      lock_o
);

   localparam logic [ADDR_W-1:0] IRQ_ADDR  = ADDR_W'(BASE + irq_ofs(REG_N));
   localparam logic [ADDR_W-1:0] LOCK_ADDR = ADDR_W'(BASE + lock_ofs(REG_N));

   logic [REG_N*DATA_W-1:0] cond_flat;
   logic [DATA_W-1:0]       slot_data [REG_N];
   logic [REG_N-1:0]        addr_hit;
   logic [REG_N-1:0]        wr_ok;
   logic [REG_N-1:0]        rd_hit;
   logic [REG_N-1:0]        slot_nz;
   logic [REG_N-1:0]        irq_cap;
   logic                    irq_sel;
   logic                    lock_sel;
   logic                    bank_open;
   logic [DATA_W-1:0]       rd_mux;

   logic [DATA_W-1:0]       rd_data_reg;
   logic [REG_N-1:0]        reg_wr_reg;
   logic [REG_N-1:0]        reg_rd_reg;
   logic [REG_N-1:0]        irq_en_reg;
   logic                    irq_reg;

   assign irq_sel  = (rbus_addr_i == IRQ_ADDR);
   assign lock_sel = (rbus_addr_i == LOCK_ADDR);

   in_cond #(
      .W         (REG_N*DATA_W),
      .SYNC_W    (SYNC_W),
      .SYNC_MASK (SYNC_VEC)
   ) u_in_cond (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .data_i  (reg_data_i),
      .data_o  (cond_flat)
   );

   genvar gi;
   generate
      for (gi = 0; gi < REG_N; gi++) begin : g_slot
         localparam mode_t SLOT_MODE = mode_t'(MODE_VEC[2*gi +: 2]);

         assign addr_hit[gi] = (rbus_addr_i == ADDR_W'(BASE + gi));
         assign rd_hit[gi]   = rbus_rd_i & addr_hit[gi];
         // RO never accepts writes; RC writes do nothing, so lock does not gate them.
         assign wr_ok[gi]    = rbus_wr_i & addr_hit[gi] & (SLOT_MODE != RO) &
                               (bank_open | (SLOT_MODE == RC));
         assign irq_cap[gi]  = (SLOT_MODE == W1C) || (SLOT_MODE == RC);
         assign slot_nz[gi]  = |slot_data[gi];
         assign reg_data_o[gi*DATA_W +: DATA_W] = slot_data[gi];

         hive_reg_slot #(
            .DATA_W    (DATA_W),
            .MODE      (SLOT_MODE),
            .LIVE      (LIVE_VEC[gi*DATA_W +: DATA_W]),
            .RESET_VAL (RESET_VEC[gi*DATA_W +: DATA_W])
         ) u_slot (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .wr_i      (wr_ok[gi]),
            .rd_i      (rd_hit[gi]),
            .wr_data_i (rbus_wr_data_i),
            .cond_i    (cond_flat[gi*DATA_W +: DATA_W]),
            .data_o    (slot_data[gi])
         );
      end
   endgenerate

`ifdef HIVE_REG_BANK_LOCK_EN
   localparam logic [DATA_W-1:0] KEY_WORD = DATA_W'(LOCK_KEY);
   lock_st_t lock_state_reg;

   // Two-write unlock sequence: key, then inverted key as the very next write.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         lock_state_reg <= LOCKED;
      end else if (rbus_wr_i) begin
         case (lock_state_reg)
            LOCKED:  if (lock_sel && rbus_wr_data_i == KEY_WORD) lock_state_reg <= ARMED;
            ARMED:   lock_state_reg <= (lock_sel && rbus_wr_data_i == ~KEY_WORD) ? OPEN : LOCKED;
            OPEN:    if (lock_sel) lock_state_reg <= LOCKED;
            default: lock_state_reg <= LOCKED;
         endcase
      end
   end

   assign bank_open = (lock_state_reg == OPEN);
   assign lock_o    = ~bank_open;
`else
   assign bank_open = 1'b1;
   assign lock_o    = 1'b0;
`endif

   // Read mux over registers, IRQ enable and lock state; 0 when out of bank.
   always_comb begin
      rd_mux = '0;
      for (int k = 0; k < REG_N; k++) begin
         if (addr_hit[k]) rd_mux = slot_data[k];
      end
      if (irq_sel) rd_mux = DATA_W'(irq_en_reg);
`ifdef HIVE_REG_BANK_LOCK_EN
      if (lock_sel) rd_mux = DATA_W'(lock_state_reg);
`endif
   end

   // Registered read data, strobes, IRQ enable and aggregated interrupt.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rd_data_reg <= '0;
         reg_wr_reg  <= '0;
         reg_rd_reg  <= '0;
         irq_en_reg  <= '0;
         irq_reg     <= 1'b0;
      end else begin
         rd_data_reg <= rbus_rd_i ? rd_mux : '0;
         reg_wr_reg  <= wr_ok;
         reg_rd_reg  <= rd_hit;
         irq_reg     <= |(irq_en_reg & slot_nz);
         if (rbus_wr_i && irq_sel && bank_open)
            irq_en_reg <= rbus_wr_data_i[REG_N-1:0] & irq_cap;
      end
   end

   assign rbus_rd_data_o = rd_data_reg;
   assign reg_wr_o       = reg_wr_reg;
   assign reg_rd_o       = reg_rd_reg;
   assign irq_o          = irq_reg;

endmodule
